// File: rtl/fa16_rev_pkg.sv
// Shared types and constants for the reversible 16-bit adder sequencer.
package fa16_rev_pkg;

    localparam int unsigned DATA_W         = 16;
    localparam int unsigned CNT_W          = 4;
    localparam int unsigned SETTLE_CYC_DEF = 2;
    localparam int unsigned SETTLE_CYC_MIN = 1;
    localparam int unsigned SETTLE_CYC_MAX = 15;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        FWD  = 3'd1,
        TURN = 3'd2,
        REV  = 3'd3,
        RESP = 3'd4
    } state_e;

    // Counter load value for a settle window; out-of-range windows are clamped.
    function automatic logic [CNT_W-1:0] settle_load(input int unsigned cyc);
        int unsigned c;
        c = cyc;
        if (c < SETTLE_CYC_MIN) c = SETTLE_CYC_MIN;
        if (c > SETTLE_CYC_MAX) c = SETTLE_CYC_MAX;
        return CNT_W'(c - 1);
    endfunction

endpackage

// File: rtl/fa16_rev_seq.sv
// Sequencer that runs an external reversible adder forward, then backward,
// and flags a response error when the backward pass misses the operands.
module fa16_rev_seq
    import fa16_rev_pkg::*;
#(
    parameter int unsigned SETTLE_CYC = SETTLE_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    input  logic              req_c0,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_s,
    output logic              rsp_c15,
    output logic              rsp_err,
    output logic              dir,
    output logic [DATA_W-1:0] f_a,
    output logic [DATA_W-1:0] f_b,
    output logic              f_c0_f,
    output logic              f_z,
    input  logic [DATA_W-1:0] f_s,
    input  logic [DATA_W-1:0] f_a_b,
    input  logic              f_c0_b,
    input  logic              f_c15,
    output logic [DATA_W-1:0] r_s,
    output logic [DATA_W-1:0] r_a_b,
    output logic              r_c0_b,
    output logic              r_c15,
    input  logic [DATA_W-1:0] r_a,
    input  logic [DATA_W-1:0] r_b,
    input  logic              r_c0_f,
    input  logic              r_z
);

    localparam logic [CNT_W-1:0] CNT_LOAD = settle_load(SETTLE_CYC);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] op_a_q, op_a_d;
    logic [DATA_W-1:0] op_b_q, op_b_d;
    logic              op_c0_q, op_c0_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_s_q, rsp_s_d;
    logic              rsp_c15_q, rsp_c15_d;
    logic              rsp_err_q, rsp_err_d;
    logic              dir_q, dir_d;
    logic [DATA_W-1:0] f_a_q, f_a_d;
    logic [DATA_W-1:0] f_b_q, f_b_d;
    logic              f_c0_f_q, f_c0_f_d;
    logic              f_z_q, f_z_d;
    logic [DATA_W-1:0] r_s_q, r_s_d;
    logic [DATA_W-1:0] r_a_b_q, r_a_b_d;
    logic              r_c0_b_q, r_c0_b_d;
    logic              r_c15_q, r_c15_d;
    logic              accept;
    logic              cnt_done;
    logic              rev_mismatch;

    assign accept       = req_valid && req_ready_q && (state_q == IDLE);
    assign cnt_done     = (cnt_q == '0);
    assign rev_mismatch = (r_a != op_a_q) || (r_b != op_b_q) ||
                          (r_c0_f != op_c0_q) || (r_z != 1'b0);

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        op_c0_d     = op_c0_q;
        rsp_valid_d = rsp_valid_q;
        rsp_s_d     = rsp_s_q;
        rsp_c15_d   = rsp_c15_q;
        rsp_err_d   = rsp_err_q;
        dir_d       = dir_q;
        f_a_d       = f_a_q;
        f_b_d       = f_b_q;
        f_c0_f_d    = f_c0_f_q;
        f_z_d       = f_z_q;
        r_s_d       = r_s_q;
        r_a_b_d     = r_a_b_q;
        r_c0_b_d    = r_c0_b_q;
        r_c15_d     = r_c15_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    op_a_d   = req_a;
                    op_b_d   = req_b;
                    op_c0_d  = req_c0;
                    f_a_d    = req_a;
                    f_b_d    = req_b;
                    f_c0_f_d = req_c0;
                    f_z_d    = 1'b0;
                    dir_d    = 1'b0;
                    cnt_d    = CNT_LOAD;
                    state_d  = FWD;
                end
            end
            FWD: begin
                // The r_* drive registers double as the forward result capture.
                if (cnt_done) begin
                    r_s_d    = f_s;
                    r_a_b_d  = f_a_b;
                    r_c0_b_d = f_c0_b;
                    r_c15_d  = f_c15;
                    dir_d    = 1'b1;
                    state_d  = TURN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            TURN: begin
                cnt_d   = CNT_LOAD;
                state_d = REV;
            end
            REV: begin
                if (cnt_done) begin
                    rsp_s_d     = r_s_q;
                    rsp_c15_d   = r_c15_q;
                    rsp_err_d   = rev_mismatch;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    dir_d       = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        req_ready_d = (state_d == IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_c0_q     <= 1'b0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_s_q     <= '0;
            rsp_c15_q   <= 1'b0;
            rsp_err_q   <= 1'b0;
            dir_q       <= 1'b0;
            f_a_q       <= '0;
            f_b_q       <= '0;
            f_c0_f_q    <= 1'b0;
            f_z_q       <= 1'b0;
            r_s_q       <= '0;
            r_a_b_q     <= '0;
            r_c0_b_q    <= 1'b0;
            r_c15_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_c0_q     <= op_c0_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_s_q     <= rsp_s_d;
            rsp_c15_q   <= rsp_c15_d;
            rsp_err_q   <= rsp_err_d;
            dir_q       <= dir_d;
            f_a_q       <= f_a_d;
            f_b_q       <= f_b_d;
            f_c0_f_q    <= f_c0_f_d;
            f_z_q       <= f_z_d;
            r_s_q       <= r_s_d;
            r_a_b_q     <= r_a_b_d;
            r_c0_b_q    <= r_c0_b_d;
            r_c15_q     <= r_c15_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_s     = rsp_s_q;
    assign rsp_c15   = rsp_c15_q;
    assign rsp_err   = rsp_err_q;
    assign dir       = dir_q;
    assign f_a       = f_a_q;
    assign f_b       = f_b_q;
    assign f_c0_f    = f_c0_f_q;
    assign f_z       = f_z_q;
    assign r_s       = r_s_q;
    assign r_a_b     = r_a_b_q;
    assign r_c0_b    = r_c0_b_q;
    assign r_c15     = r_c15_q;

endmodule

// File: tb/tb_fa16_rev_seq.sv
// Scoreboard bench: three sequencers (settle 2, 1, 15) around a behavioural
// reversible adder, with an optional backward-path bit fault on the first.
module tb_fa16_rev_seq;

    typedef struct packed {
        logic [15:0] s;
        logic        c15;
        logic        err;
    } exp_t;

    logic clk;
    logic rst;
    logic flt;

    logic [2:0]       req_valid, req_c0, rsp_ready;
    logic [2:0][15:0] req_a, req_b;

    wire [2:0]       req_ready, rsp_valid, rsp_c15, rsp_err, dir;
    wire [2:0]       f_c0_f, f_z, f_c0_b, f_c15, r_c0_b, r_c15, r_c0_f, r_z;
    wire [2:0][15:0] rsp_s, f_a, f_b, f_s, f_a_b, r_s, r_a_b, r_a, r_b;

    exp_t sb[$];
    int   nvec;
    int   nerr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        wire [16:0] fsum;
        wire [16:0] rdiff;

        fa16_rev_seq #(
            .SETTLE_CYC((g == 0) ? 2 : ((g == 1) ? 1 : 15))
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .req_valid(req_valid[g]),
            .req_ready(req_ready[g]),
            .req_a    (req_a[g]),
            .req_b    (req_b[g]),
            .req_c0   (req_c0[g]),
            .rsp_valid(rsp_valid[g]),
            .rsp_ready(rsp_ready[g]),
            .rsp_s    (rsp_s[g]),
            .rsp_c15  (rsp_c15[g]),
            .rsp_err  (rsp_err[g]),
            .dir      (dir[g]),
            .f_a      (f_a[g]),
            .f_b      (f_b[g]),
            .f_c0_f   (f_c0_f[g]),
            .f_z      (f_z[g]),
            .f_s      (f_s[g]),
            .f_a_b    (f_a_b[g]),
            .f_c0_b   (f_c0_b[g]),
            .f_c15    (f_c15[g]),
            .r_s      (r_s[g]),
            .r_a_b    (r_a_b[g]),
            .r_c0_b   (r_c0_b[g]),
            .r_c15    (r_c15[g]),
            .r_a      (r_a[g]),
            .r_b      (r_b[g]),
            .r_c0_f   (r_c0_f[g]),
            .r_z      (r_z[g])
        );

        // Reversible adder: forward keeps a and c0 as garbage outputs, backward recomputes b.
        assign fsum      = 17'(f_a[g]) + 17'(f_b[g]) + 17'(f_c0_f[g]);
        assign f_s[g]    = fsum[15:0];
        assign f_c15[g]  = fsum[16];
        assign f_a_b[g]  = f_a[g];
        assign f_c0_b[g] = f_c0_f[g];
        assign rdiff     = {r_c15[g], r_s[g]} - 17'(r_a_b[g]) - 17'(r_c0_b[g]);
        assign r_a[g]    = r_a_b[g];
        assign r_b[g]    = rdiff[15:0] ^ (((g == 0) && flt && dir[g]) ? 16'h0008 : 16'h0000);
        assign r_c0_f[g] = r_c0_b[g];
        assign r_z[g]    = rdiff[16];
    end

    function automatic int settle_of(input int g);
        return (g == 0) ? 2 : ((g == 1) ? 1 : 15);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input int g, input logic [15:0] a, input logic [15:0] b, input logic c0);
        logic [16:0] sum;
        exp_t e;
        sum   = 17'(a) + 17'(b) + 17'(c0);
        e.s   = sum[15:0];
        e.c15 = sum[16];
        e.err = (g == 0) && flt;
        sb.push_back(e);
    endtask

    // Offer one request; returns just after its acceptance edge.
    task automatic issue(input int g, input logic [15:0] a, input logic [15:0] b, input logic c0);
        int n;
        @(negedge clk);
        req_valid[g] = 1'b1;
        req_a[g]     = a;
        req_b[g]     = b;
        req_c0[g]    = c0;
        n = 0;
        while (!req_ready[g] && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready[g]) chk("req_ready_timeout", 32'(req_ready[g]), 32'd1);
        @(posedge clk);
        push_exp(g, a, b, c0);
        #1;
        req_valid[g] = 1'b0;
        req_a[g]     = ~a;
        req_b[g]     = ~b;
        req_c0[g]    = ~c0;
    endtask

    // Wait for the response, check latency, direction profile and payload.
    task automatic collect(input int g);
        int   lat, n0, n1, s;
        exp_t e;
        s   = settle_of(g);
        lat = 0;
        n0  = 0;
        n1  = 0;
        @(negedge clk);
        while (!rsp_valid[g] && lat < 64) begin
            if (dir[g]) n1++;
            else n0++;
            chk("f_z_low", 32'(f_z[g]), 32'd0);
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk("latency", 32'(lat), 32'(2 * s + 1));
        chk("dir_fwd_cycles", 32'(n0), 32'(s));
        chk("dir_rev_cycles", 32'(n1), 32'(s + 1));
        chk("resp_req_ready", 32'(req_ready[g]), 32'd0);
        chk("resp_dir", 32'(dir[g]), 32'd1);
        if (sb.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("rsp_s", 32'(rsp_s[g]), 32'(e.s));
            chk("rsp_c15", 32'(rsp_c15[g]), 32'(e.c15));
            chk("rsp_err", 32'(rsp_err[g]), 32'(e.err));
        end
    endtask

    task automatic release_rsp(input int g);
        rsp_ready[g] = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready[g] = 1'b0;
        @(negedge clk);
        chk("rel_rsp_valid", 32'(rsp_valid[g]), 32'd0);
        chk("rel_dir", 32'(dir[g]), 32'd0);
        chk("rel_req_ready", 32'(req_ready[g]), 32'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] held_s;
        logic        held_err;
        nvec      = 0;
        nerr      = 0;
        flt       = 1'b0;
        rst       = 1'b1;
        req_valid = '0;
        req_c0    = '0;
        rsp_ready = '0;
        req_a     = '0;
        req_b     = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_dir", 32'(dir), 32'd0);
        chk("rst_rsp_s", 32'(rsp_s[0]), 32'd0);
        chk("rst_f_a", 32'(f_a[0]), 32'd0);
        chk("rst_r_s", 32'(r_s[0]), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_no_edge_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        chk("post_rst_ready", 32'(req_ready), 32'd7);

        // Stray rsp_ready while idle
        rsp_ready[0] = 1'b1;
        @(negedge clk);
        rsp_ready[0] = 1'b0;
        chk("stray_rsp_ready_valid", 32'(rsp_valid[0]), 32'd0);
        chk("stray_rsp_ready_ready", 32'(req_ready[0]), 32'd1);

        // Basic add and full-carry add
        issue(0, 16'h1234, 16'h0FF0, 1'b0);
        collect(0);
        release_rsp(0);
        issue(0, 16'hFFFF, 16'h0001, 1'b1);
        collect(0);
        release_rsp(0);

        // Backward-path fault must flag err but keep the forward sum
        flt = 1'b1;
        issue(0, 16'hA5A5, 16'h0F0F, 1'b0);
        collect(0);
        release_rsp(0);
        flt = 1'b0;

        // Back-pressure: response holds, busy requests ignored
        issue(0, 16'h00FF, 16'h0100, 1'b0);
        collect(0);
        held_s       = 16'h01FF;
        held_err     = 1'b0;
        req_valid[0] = 1'b1;
        req_a[0]     = 16'h7777;
        req_b[0]     = 16'h1111;
        repeat (10) begin
            @(negedge clk);
            chk("hold_rsp_valid", 32'(rsp_valid[0]), 32'd1);
            chk("hold_rsp_s", 32'(rsp_s[0]), 32'(held_s));
            chk("hold_rsp_err", 32'(rsp_err[0]), 32'(held_err));
            chk("hold_req_ready", 32'(req_ready[0]), 32'd0);
        end
        rsp_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready[0] = 1'b0;
        req_valid[0] = 1'b0;
        @(negedge clk);
        chk("hold_rel_ready", 32'(req_ready[0]), 32'd1);
        chk("hold_rel_dir", 32'(dir[0]), 32'd0);
        repeat (8) @(negedge clk);
        chk("busy_req_not_latched", 32'(rsp_valid[0]), 32'd0);

        // Response handshake coincident with a new request
        issue(0, 16'h8000, 16'h8000, 1'b0);
        collect(0);
        rsp_ready[0] = 1'b1;
        req_valid[0] = 1'b1;
        req_a[0]     = 16'h0003;
        req_b[0]     = 16'h0004;
        req_c0[0]    = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready[0] = 1'b0;
        @(negedge clk);
        chk("b2b_rsp_valid", 32'(rsp_valid[0]), 32'd0);
        chk("b2b_req_ready", 32'(req_ready[0]), 32'd1);
        @(posedge clk);
        push_exp(0, 16'h0003, 16'h0004, 1'b1);
        #1;
        req_valid[0] = 1'b0;
        collect(0);
        release_rsp(0);

        // Reset during REV aborts the operation
        issue(0, 16'h4321, 16'h1111, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_rsp_valid", 32'(rsp_valid[0]), 32'd0);
        chk("abort_dir", 32'(dir[0]), 32'd0);
        chk("abort_req_ready", 32'(req_ready[0]), 32'd0);
        chk("abort_f_a", 32'(f_a[0]), 32'd0);
        chk("abort_r_s", 32'(r_s[0]), 32'd0);
        chk("abort_r_a_b", 32'(r_a_b[0]), 32'd0);
        void'(sb.pop_front());
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_post_ready", 32'(req_ready[0]), 32'd1);
        chk("abort_post_valid", 32'(rsp_valid[0]), 32'd0);
        issue(0, 16'h0005, 16'h0007, 1'b0);
        collect(0);
        release_rsp(0);

        // Settle windows of 1 and 15 cycles
        issue(1, 16'hBEEF, 16'h4111, 1'b1);
        collect(1);
        release_rsp(1);
        issue(2, 16'hF00D, 16'h0FF3, 1'b0);
        collect(2);
        release_rsp(2);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
